// File: rtl/ex_stage_md_if.sv
// Bundle of signals between the EX stage and its neighbours.
// The hazard unit and the decode stage drive the master side. ex_stage_md is the slave.
interface ex_stage_md_if #(
    parameter int WIDTH  = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8
);
    // Handshake: the stage register advances only on a rising edge where
    // we=1 and stall=0. If we=1 and stall=1, a bubble enters instead. If we=0,
    // the stage holds. The upstream stage keeps its inputs stable while stall is high.
    logic              we;
    logic              valid_in;
    logic [3:0]        md_op;
    logic [WIDTH-1:0]  data_s;
    logic [WIDTH-1:0]  data_t;
    logic [WIDTH-1:0]  alu_result;
    logic              is_link;
    logic [WIDTH-1:0]  pc_next;
    logic [WIDTH-1:0]  immediate;
    logic [REG_W-1:0]  wreg;
    logic [CTRL_W-1:0] ctrl_in;

    logic              stall;
    logic              md_busy;
    logic              valid_out;
    logic [WIDTH-1:0]  result_out;
    logic [WIDTH-1:0]  data_t_out;
    logic [REG_W-1:0]  reg_addr;
    logic [CTRL_W-1:0] ctrl_out;
    logic [WIDTH-1:0]  pc_branch;
    logic [1:0]        md_state;

    modport master (
        output we, valid_in, md_op, data_s, data_t, alu_result, is_link,
               pc_next, immediate, wreg, ctrl_in,
        input  stall, md_busy, valid_out, result_out, data_t_out, reg_addr,
               ctrl_out, pc_branch, md_state
    );

    modport slave (
        input  we, valid_in, md_op, data_s, data_t, alu_result, is_link,
               pc_next, immediate, wreg, ctrl_in,
        output stall, md_busy, valid_out, result_out, data_t_out, reg_addr,
               ctrl_out, pc_branch, md_state
    );
endinterface

// File: rtl/ex_stage_md.sv
// Execute stage register with an iterative multiply/divide unit and HI/LO registers.
// A multiply or divide keeps the unit busy for WIDTH+1 cycles. While it runs, later HI/LO ops are stalled.
module ex_stage_md #(
    parameter int WIDTH  = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8
) (
    input logic          clk,
    input logic          reset,
    ex_stage_md_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    md_state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [WIDTH-1:0]  a_q;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]  p_hi_q;    // partial product high half or running remainder
    logic [WIDTH-1:0]  p_lo_q;    // multiplier or dividend bits shifting out, result bits shifting in
    logic              is_div_q;
    logic              neg_q_q;
    logic              neg_r_q;
    logic              div_zero_q;
    logic [WIDTH-1:0]  orig_s_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic              md_busy_q;

    logic              valid_q;
    logic [WIDTH-1:0]  result_q;
    logic [WIDTH-1:0]  data_t_q;
    logic [REG_W-1:0]  reg_addr_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [WIDTH-1:0]  pc_branch_q;

    logic              md_req;
    logic              load;
    logic              start;
    logic              signed_op;
    logic              s_neg;
    logic              t_neg;
    logic [WIDTH-1:0]  s_mag;
    logic [WIDTH-1:0]  t_mag;
    logic [WIDTH-1:0]  result_d;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign md_req    = bus.valid_in && (bus.md_op != 4'd0) && (bus.md_op <= OP_MTLO);
    assign bus.stall = md_req && (state_q != IDLE);
    assign load      = bus.we && !bus.stall;
    assign start     = load && bus.valid_in && (bus.md_op != 4'd0) && (bus.md_op <= OP_DIVU);

    // Unsigned ops use the raw operands. Signed ops use magnitudes, and the signs are fixed up in FIX.
    assign signed_op = (bus.md_op == OP_MULT) || (bus.md_op == OP_DIV);
    assign s_neg     = signed_op && bus.data_s[WIDTH-1];
    assign t_neg     = signed_op && bus.data_t[WIDTH-1];
    assign s_mag     = s_neg ? (-bus.data_s) : bus.data_s;
    assign t_mag     = t_neg ? (-bus.data_t) : bus.data_t;

    assign mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, a_q} : '0);
    assign div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, a_q};

    assign prod_fix  = neg_q_q ? (-{p_hi_q, p_lo_q}) : {p_hi_q, p_lo_q};
    assign quot_fix  = neg_q_q ? (-p_lo_q) : p_lo_q;
    assign rem_fix   = neg_r_q ? (-p_hi_q) : p_hi_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            a_q        <= '0;
            p_hi_q     <= '0;
            p_lo_q     <= '0;
            is_div_q   <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            div_zero_q <= 1'b0;
            orig_s_q   <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            md_busy_q  <= 1'b0;
        end else begin
            md_busy_q <= (state_d != IDLE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q      <= CNT_W'(WIDTH);
                        is_div_q   <= (bus.md_op == OP_DIV) || (bus.md_op == OP_DIVU);
                        a_q        <= t_mag;
                        p_hi_q     <= '0;
                        p_lo_q     <= s_mag;
                        neg_q_q    <= s_neg ^ t_neg;
                        neg_r_q    <= s_neg;
                        div_zero_q <= (bus.data_t == '0);
                        orig_s_q   <= bus.data_s;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (is_div_q) begin
                        if (!div_trial[WIDTH]) begin
                            p_hi_q <= div_trial[WIDTH-1:0];
                            p_lo_q <= {p_lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            p_hi_q <= div_shift[WIDTH-1:0];
                            p_lo_q <= {p_lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        p_hi_q <= mul_sum[WIDTH:1];
                        p_lo_q <= {mul_sum[0], p_lo_q[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (!is_div_q) begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else if (div_zero_q) begin
                        hi_q <= orig_s_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end
                end
                default: ;
            endcase
            // MTHI/MTLO can only load while the unit is idle, so they never collide with FIX.
            if (load && bus.valid_in && (bus.md_op == OP_MTHI)) hi_q <= bus.data_s;
            if (load && bus.valid_in && (bus.md_op == OP_MTLO)) lo_q <= bus.data_s;
        end
    end

    always_comb begin
        result_d = bus.alu_result;
        if (bus.is_link)                 result_d = bus.pc_next;
        else if (bus.md_op == OP_MFHI)   result_d = hi_q;
        else if (bus.md_op == OP_MFLO)   result_d = lo_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            data_t_q    <= '0;
            reg_addr_q  <= '0;
            ctrl_q      <= '0;
            pc_branch_q <= '0;
        end else if (bus.we) begin
            if (bus.stall) begin
                valid_q     <= 1'b0;
                result_q    <= '0;
                data_t_q    <= '0;
                reg_addr_q  <= '0;
                ctrl_q      <= '0;
                pc_branch_q <= '0;
            end else begin
                valid_q     <= bus.valid_in;
                result_q    <= result_d;
                data_t_q    <= bus.data_t;
                reg_addr_q  <= bus.wreg;
                ctrl_q      <= bus.ctrl_in;
                pc_branch_q <= bus.pc_next + (bus.immediate << 2);
            end
        end
    end

    assign bus.md_busy    = md_busy_q;
    assign bus.valid_out  = valid_q;
    assign bus.result_out = result_q;
    assign bus.data_t_out = data_t_q;
    assign bus.reg_addr   = reg_addr_q;
    assign bus.ctrl_out   = ctrl_q;
    assign bus.pc_branch  = pc_branch_q;
    assign bus.md_state   = state_q;
endmodule

// File: tb/tb_ex_stage_md.sv
// Bench for ex_stage_md at WIDTH=32. Driver tasks push the expected stage output when an instruction is accepted.
// A monitor compares every loaded stage register against that queue.
module tb_ex_stage_md;
  localparam int W     = 32;
  localparam int RW    = 5;
  localparam int CW    = 8;
  localparam int EXP_W = 3 * W + RW + CW;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic clk;
  logic reset;
  int n_tests = 0;
  int n_fail  = 0;
  int last_stalls;
  logic [EXP_W-1:0] exp_q[$];

  ex_stage_md_if #(.WIDTH(W), .REG_W(RW), .CTRL_W(CW)) bus ();

  ex_stage_md #(.WIDTH(W), .REG_W(RW), .CTRL_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks: called at a falling edge, return at a falling edge
  task automatic issue(input logic [3:0] op, input logic [W-1:0] s, input logic [W-1:0] t,
                       input logic [W-1:0] alu, input logic link, input logic [W-1:0] pcn,
                       input logic [W-1:0] imm, input logic [W-1:0] exp_res,
                       input logic [W-1:0] exp_pcb);
    logic [RW-1:0] wr;
    logic [CW-1:0] cr;
    bit acc;
    wr = RW'($urandom_range(0, 31));
    cr = CW'($urandom_range(1, 255));
    bus.we = 1'b1;
    bus.valid_in = 1'b1;
    bus.md_op = op;
    bus.data_s = s;
    bus.data_t = t;
    bus.alu_result = alu;
    bus.is_link = link;
    bus.pc_next = pcn;
    bus.immediate = imm;
    bus.wreg = wr;
    bus.ctrl_in = cr;
    acc = 1'b0;
    last_stalls = 0;
    for (int c = 0; c < 200 && !acc; c++) begin
      #4;
      if (bus.stall) last_stalls++;
      else begin
        acc = 1'b1;
        exp_q.push_back({exp_res, t, exp_pcb, wr, cr});
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: op %0d never accepted, expected acceptance within 200 cycles", op);
    end
    bus.valid_in = 1'b0;
    bus.md_op = OP_NONE;
    bus.is_link = 1'b0;
  endtask

  task automatic md(input logic [3:0] op, input logic [W-1:0] s, input logic [W-1:0] t,
                    input logic [W-1:0] alu, input logic [W-1:0] exp_res);
    logic [W-1:0] pcn;
    logic [W-1:0] imm;
    pcn = $urandom;
    imm = W'($urandom_range(0, 255));
    issue(op, s, t, alu, 1'b0, pcn, imm, exp_res, pcn + (imm << 2));
  endtask

  // scoreboard monitor
  initial begin
    logic took;
    logic bub;
    logic [EXP_W-1:0] exp_v;
    logic [EXP_W-1:0] got_v;
    forever begin
      @(negedge clk);
      #4;
      took = reset && bus.we && !bus.stall && bus.valid_in;
      bub  = reset && bus.we && bus.stall;
      @(posedge clk);
      #1;
      if (took) begin
        n_tests++;
        got_v = {bus.result_out, bus.data_t_out, bus.pc_branch, bus.reg_addr, bus.ctrl_out};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stage_out: got 0x%h with no expected entry queued", got_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (got_v !== exp_v || bus.valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL stage_out: got 0x%h valid %b expected 0x%h valid 1", got_v, bus.valid_out, exp_v);
          end
        end
      end else if (bub) begin
        n_tests++;
        if (bus.valid_out !== 1'b0 || bus.ctrl_out !== '0 || bus.result_out !== '0) begin
          n_fail++;
          $display("FAIL bubble: got valid %b ctrl 0x%h result 0x%h expected all 0",
                   bus.valid_out, bus.ctrl_out, bus.result_out);
        end
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // directed sequence
  initial begin
    int e;
    reset = 1'b0;
    bus.we = 1'b0;
    bus.valid_in = 1'b0;
    bus.md_op = OP_NONE;
    bus.data_s = '0;
    bus.data_t = '0;
    bus.alu_result = '0;
    bus.is_link = 1'b0;
    bus.pc_next = '0;
    bus.immediate = '0;
    bus.wreg = '0;
    bus.ctrl_in = '0;
    repeat (3) @(negedge clk);
    check("rst_valid_out", W'(bus.valid_out), 0);
    check("rst_md_busy", W'(bus.md_busy), 0);
    check("rst_result", bus.result_out, 0);
    check("rst_pc_branch", bus.pc_branch, 0);
    reset = 1'b1;
    bus.we = 1'b1;
    @(negedge clk);

    // plain ALU, link and branch-target paths
    issue(OP_NONE, 32'h0, 32'h5555AAAA, 32'h12345678, 1'b0, 32'h100, 32'h3, 32'h12345678, 32'h10C);
    issue(OP_NONE, 32'h0, 32'h1, 32'h0000DEAD, 1'b1, 32'h400, 32'hFFFFFFFF, 32'h400, 32'h3FC);

    // MTHI/MTLO then read back
    md(OP_MTHI, 32'hCAFEBABE, 32'h0, 32'h11, 32'h11);
    md(OP_MTLO, 32'h0BADF00D, 32'h0, 32'h22, 32'h22);
    md(OP_MFHI, 32'h0, 32'h0, 32'h33, 32'hCAFEBABE);
    md(OP_MFLO, 32'h0, 32'h0, 32'h44, 32'h0BADF00D);

    // unsigned max x max, MFLO right behind it stalls for the whole operation
    md(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55, 32'h55);
    check("multu_start_stalls", last_stalls, 0);
    md(OP_MFLO, 32'h0, 32'h0, 32'h0, 32'h00000001);
    check("mflo_stall_cycles", last_stalls, 33);
    md(OP_MFHI, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFE);

    // signed multiply; an out-of-range op code is not an HI/LO op and must not stall
    md(OP_MULT, 32'hFFFFFFFD, 32'h5, 32'h66, 32'h66);
    md(4'd12, 32'h0, 32'h0, 32'hA5, 32'hA5);
    check("op12_no_stall", last_stalls, 0);
    md(OP_MFHI, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF);
    md(OP_MFLO, 32'h0, 32'h0, 32'h0, 32'hFFFFFFF1);

    // divides
    md(OP_DIV, 32'hFFFFFFF9, 32'h2, 32'h0, 32'h0);
    md(OP_MFLO, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFD);
    md(OP_MFHI, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF);
    md(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0);
    md(OP_MFLO, 32'h0, 32'h0, 32'h0, 32'h80000000);
    md(OP_MFHI, 32'h0, 32'h0, 32'h0, 32'h00000000);
    md(OP_DIVU, 32'h5, 32'h0, 32'h0, 32'h0);
    md(OP_MFLO, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF);
    md(OP_MFHI, 32'h0, 32'h0, 32'h0, 32'h00000005);
    md(OP_DIV, 32'hFFFFFFF9, 32'h0, 32'h0, 32'h0);
    md(OP_MFLO, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF);
    md(OP_MFHI, 32'h0, 32'h0, 32'h0, 32'hFFFFFFF9);
    md(OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0, 32'h0);
    md(OP_MFLO, 32'h0, 32'h0, 32'h0, 32'h0FFFFFFF);
    md(OP_MFHI, 32'h0, 32'h0, 32'h0, 32'h0000000F);

    // we=0 for 5 cycles while the multiply runs: stage holds, unit keeps iterating
    md(OP_MULTU, 32'h00010000, 32'h00010000, 32'h77, 32'h77);
    bus.we = 1'b0;
    for (e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      check("hold_valid", W'(bus.valid_out), 1);
      check("hold_result", bus.result_out, 32'h77);
      check("hold_busy", W'(bus.md_busy), 1);
    end
    @(negedge clk);
    bus.we = 1'b1;
    for (e = 6; e < 100; e++) begin
      @(posedge clk);
      #1;
      if (!bus.md_busy) break;
    end
    check("busy_edges", e, 33);
    @(negedge clk);
    md(OP_MFHI, 32'h0, 32'h0, 32'h0, 32'h00000001);
    md(OP_MFLO, 32'h0, 32'h0, 32'h0, 32'h00000000);

    // reset in the middle of RUN
    md(OP_MULTU, 32'h00001234, 32'h00005678, 32'h88, 32'h88);
    bus.we = 1'b0;
    bus.valid_in = 1'b1;
    bus.md_op = OP_MFLO;
    repeat (9) @(negedge clk);
    check("pre_rst_stall", W'(bus.stall), 1);
    check("pre_rst_valid", W'(bus.valid_out), 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_busy", W'(bus.md_busy), 0);
    check("mid_rst_stall", W'(bus.stall), 0);
    check("mid_rst_valid", W'(bus.valid_out), 0);
    check("mid_rst_result", bus.result_out, 0);
    check("mid_rst_state", W'(bus.md_state), 0);
    check("mid_rst_hi", dut.hi_q, 0);
    check("mid_rst_lo", dut.lo_q, 0);
    check("mid_rst_cnt", W'(dut.cnt_q), 0);
    bus.valid_in = 1'b0;
    bus.md_op = OP_NONE;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus.we = 1'b1;
    md(OP_MFHI, 32'h0, 32'h0, 32'h0, 32'h0);
    md(OP_MFLO, 32'h0, 32'h0, 32'h0, 32'h0);
    md(OP_MULTU, 32'h89ABCDEF, 32'h10, 32'h99, 32'h99);
    md(OP_MFHI, 32'h0, 32'h0, 32'h0, 32'h00000008);
    md(OP_MFLO, 32'h0, 32'h0, 32'h0, 32'h9ABCDEF0);

    repeat (3) @(negedge clk);
    check("queue_drained", W'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
